// File: rtl/spi_gpio_master_pkg.sv
// Shared state encoding, default timing and width helper for the SPI GPIO master
// and anything that needs to agree with it on framing.
package spi_gpio_master_pkg;

   localparam int DEF_NREQ      = 2;
   localparam int DEF_CLK_DIV   = 4;
   localparam int DEF_GAP       = 4;
   localparam int BITS_PER_XFER = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_LOW,
      ST_HIGH,
      ST_GAP
   } state_e;

   // Width of an index or counter that must hold 0..n-1, never narrower than one bit.
   function automatic int min1_clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/spi_gpio_master_if.sv
// Request side of the SPI GPIO master: per-requester valid/data in, one-hot ready out.
interface spi_gpio_master_if #(
   parameter int NREQ = 2
);

   logic [NREQ-1:0]   req_valid_i;
   logic [8*NREQ-1:0] req_data_i;
   logic [NREQ-1:0]   req_ready_o;

   modport master (output req_valid_i, req_data_i, input req_ready_o);
   modport slave  (input req_valid_i, req_data_i, output req_ready_o);

endinterface

// File: rtl/spi_gpio_master_rr_arbiter.sv
// Round-robin arbiter: searches upward from a rotating pointer and moves the
// pointer past the winner whenever a grant is taken.
module rr_arbiter
   import spi_gpio_master_pkg::*;
#(
   parameter  int N  = 2,
   localparam int IW = min1_clog2(N)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] index
);

   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] cidx;
   logic          found;
   int            cand;

   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      cand  = 0;
      cidx  = '0;
      for (int off = 0; off < N; off++) begin
         cand = (int'(ptr_q) + off) % N;
         cidx = IW'(cand);
         if (!found && req[cidx]) begin
            found       = 1'b1;
            grant[cidx] = 1'b1;
            index       = cidx;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && found)
         ptr_d = (index == IW'(N - 1)) ? '0 : index + IW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/spi_gpio_master.sv
// SPI master that pushes one arbitrated GPIO byte per cs_n frame, LSB first,
// with sclk idling high and the slave sampling on the falling edge.
module spi_gpio_master
   import spi_gpio_master_pkg::*;
#(
   parameter  int NREQ    = DEF_NREQ,
   parameter  int CLK_DIV = DEF_CLK_DIV,
   parameter  int GAP     = DEF_GAP,
   localparam int IW      = min1_clog2(NREQ)
)(
   input  logic             clk,
   input  logic             rst,
   spi_gpio_master_if.slave bus,
   output logic             sclk_o,
   output logic             mosi_o,
   output logic             cs_n_o,
   output logic             busy_o,
   output logic [IW-1:0]    grant_o
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int GAP_W = min1_clog2(GAP);

   state_e            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [2:0]        bit_q, bit_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [7:0]        shift_q, shift_d;
   logic              sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d, busy_q, busy_d;
   logic [NREQ-1:0]   ready_q, ready_d;
   logic [IW-1:0]     grant_q, grant_d;

   logic [NREQ-1:0]   arb_grant;
   logic [IW-1:0]     arb_index;
   logic [7:0]        sel_data;
   logic              phase_end, last_bit;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (bus.req_valid_i),
      .advance (state_q == ST_IDLE),
      .grant   (arb_grant),
      .index   (arb_index)
   );

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++)
         if (arb_grant[i]) sel_data = bus.req_data_i[8*i +: 8];
   end

   assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
   assign last_bit  = (bit_q == 3'(BITS_PER_XFER - 1));

   // The shift register rotates so the next bit is always at [1]; the hold HIGH
   // after the last falling edge keeps mosi on bit 7.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      gap_d   = gap_q;
      shift_d = shift_q;
      sclk_d  = sclk_q;
      mosi_d  = mosi_q;
      cs_n_d  = cs_n_q;
      busy_d  = busy_q;
      grant_d = grant_q;
      ready_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (|bus.req_valid_i) begin
               ready_d = arb_grant;
               grant_d = arb_index;
               shift_d = sel_data;
               mosi_d  = sel_data[0];
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               div_d   = '0;
               bit_d   = '0;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            div_d = div_q + DIV_W'(1);
            if (phase_end) begin
               div_d   = '0;
               sclk_d  = 1'b0;
               state_d = ST_LOW;
            end
         end
         ST_LOW: begin
            div_d = div_q + DIV_W'(1);
            if (phase_end) begin
               div_d   = '0;
               sclk_d  = 1'b1;
               state_d = ST_HIGH;
               if (!last_bit) begin
                  shift_d = {shift_q[0], shift_q[7:1]};
                  mosi_d  = shift_q[1];
               end
            end
         end
         ST_HIGH: begin
            div_d = div_q + DIV_W'(1);
            if (phase_end) begin
               div_d = '0;
               if (last_bit) begin
                  cs_n_d  = 1'b1;
                  mosi_d  = 1'b0;
                  gap_d   = '0;
                  state_d = ST_GAP;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  sclk_d  = 1'b0;
                  state_d = ST_LOW;
               end
            end
         end
         ST_GAP: begin
            gap_d = gap_q + GAP_W'(1);
            if (gap_q == GAP_W'(GAP - 1)) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         shift_q <= '0;
         sclk_q  <= 1'b1;
         mosi_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= '0;
         grant_q <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         shift_q <= shift_d;
         sclk_q  <= sclk_d;
         mosi_q  <= mosi_d;
         cs_n_q  <= cs_n_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         grant_q <= grant_d;
      end
   end

   assign sclk_o          = sclk_q;
   assign mosi_o          = mosi_q;
   assign cs_n_o          = cs_n_q;
   assign busy_o          = busy_q;
   assign grant_o         = grant_q;
   assign bus.req_ready_o = ready_q;

endmodule
